spectro_readout_seq: RTL and testbench

Parametrised serial readout sequencer for the spectrogram extractor's multi-bank channel memory.
- On each acoustic-emission (AE) event it emits one RTC timestamp header, then the memory words of every filled bank, then the partially filled final bank, as a bit-serial stream.
- Generalises the two-bank readout FSM to N banks in round-robin order, with configurable depth, word and header widths.
- Adds a downstream tx_ready back-pressure handshake, synchronous capture of the final index, and sticky overflow detection.
- Sits between the bank writer and the serial output shift registers.

---
 rtl/spectro_readout_if.sv | 41 ++++
 rtl/spectro_readout_seq.sv | 275 +++++++++++++++++++++++++++
 tb/tb_spectro_readout_seq.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spectro_readout_if.sv
// spectro_readout_if
//   Groups the sequencer's event, handshake and memory/shift-control signals.
//   master : the readout sequencer (drives read strobes and shift controls)
//   slave  : the environment (bank writer, event logic, serial sink, memory)
//   Signals:
//     bank_full, acq_done, idx_final, tx_ready, clr_overflow : into the sequencer
//     rd_addr, rd_en, sl_time, sl_ch, shift_en, sel_mem,
//     sending, frame_done, overflow                           : out of the sequencer
interface spectro_readout_if #(
  parameter int BANK_W = 1,
  parameter int ADDR_W = 8
) ();

  logic                     bank_full;
  logic                     acq_done;
  logic [ADDR_W-1:0]        idx_final;
  logic                     tx_ready;
  logic                     clr_overflow;
  logic [BANK_W+ADDR_W-1:0] rd_addr;
  logic                     rd_en;
  logic                     sl_time;
  logic                     sl_ch;
  logic                     shift_en;
  logic                     sel_mem;
  logic                     sending;
  logic                     frame_done;
  logic                     overflow;

  modport master (
    input  bank_full, acq_done, idx_final, tx_ready, clr_overflow,
    output rd_addr, rd_en, sl_time, sl_ch, shift_en, sel_mem,
           sending, frame_done, overflow
  );

  modport slave (
    output bank_full, acq_done, idx_final, tx_ready, clr_overflow,
    input  rd_addr, rd_en, sl_time, sl_ch, shift_en, sel_mem,
           sending, frame_done, overflow
  );

endinterface

// File: rtl/spectro_readout_seq.sv
// spectro_readout_seq
//   Serial readout sequencer for the spectrogram extractor's multi-bank channel
//   memory. For every acoustic-emission event it emits one RTC header, then
//   every filled bank in round-robin order, then the partially filled final
//   bank, controlling the RTC and memory shift registers bit by bit.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-high reset
//   bus   : spectro_readout_if.master
//     bank_full    - pulse, writer finished a bank
//     acq_done     - pulse, event ended; idx_final is the last address written
//     tx_ready     - sink accepts a serial bit this cycle
//     clr_overflow - synchronous clear of the sticky overflow flag
//     rd_addr/rd_en          - memory read ({bank, index}), data valid next cycle
//     sl_time/sl_ch          - load RTC / memory shift register
//     shift_en/sel_mem       - shift the selected register, 0=RTC 1=memory
//     sending/frame_done     - readout busy / one-cycle completion pulse
//     overflow               - sticky error flag
module spectro_readout_seq #(
  parameter int NBANKS = 2,
  parameter int BANK_W = 1,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 200,
  parameter int WORD_W = 2,
  parameter int RTC_W  = 30
) (
  input  logic              clk,
  input  logic              reset,
  spectro_readout_if.master bus
);

  // The bit counter is shared by the header and the word shifts.
  localparam int CNT_MAX = (RTC_W > WORD_W) ? RTC_W : WORD_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  RTC_LAST   = CNT_W'(RTC_W - 1);
  localparam logic [CNT_W-1:0]  WORD_LAST  = CNT_W'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] DEPTH_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [BANK_W-1:0] PEND_MAX   = BANK_W'(NBANKS - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_RTC   = 3'd1,
    SHIFT_RTC  = 3'd2,
    FETCH      = 3'd3,
    LOAD_WORD  = 3'd4,
    SHIFT_WORD = 3'd5,
    WAIT_BANK  = 3'd6
  } state_t;

  typedef enum logic {
    MODE_FULL    = 1'b0,
    MODE_PARTIAL = 1'b1
  } mode_t;

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d;
  logic [BANK_W-1:0]   rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BANK_W-1:0]   pend_cnt_q, pend_cnt_d;
  logic                done_pend_q, done_pend_d;
  logic [ADDR_W-1:0]   final_q, final_d;
  logic                sending_q, sending_d;
  logic                frame_done_q, frame_done_d;
  logic                overflow_q, overflow_d;

  logic                do_select;
  logic                take_full;
  logic                take_partial;
  logic                ovf_set;
  logic [ADDR_W-1:0]   last_idx;

  logic [BANK_W+ADDR_W-1:0] rd_addr_c;
  logic                     rd_en_c;
  logic                     sl_time_c;
  logic                     sl_ch_c;
  logic                     shift_en_c;
  logic                     sel_mem_c;

  // A full bank ends at the last physical word; the partial bank ends at the
  // index captured when the event finished.
  assign last_idx = (mode_q == MODE_PARTIAL) ? final_q : DEPTH_LAST;

  always_comb begin : fsm_next
    state_d      = state_q;
    mode_d       = mode_q;
    rd_bank_d    = rd_bank_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    do_select    = 1'b0;
    take_full    = 1'b0;
    take_partial = 1'b0;
    rd_addr_c    = '0;
    rd_en_c      = 1'b0;
    sl_time_c    = 1'b0;
    sl_ch_c      = 1'b0;
    shift_en_c   = 1'b0;
    sel_mem_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend_cnt_q != '0 || done_pend_q) begin
          state_d = LOAD_RTC;
        end
      end

      LOAD_RTC: begin
        sl_time_c = 1'b1;
        state_d   = SHIFT_RTC;
      end

      SHIFT_RTC: begin
        shift_en_c = bus.tx_ready;
        if (bus.tx_ready) begin
          if (cnt_q == RTC_LAST) begin
            cnt_d     = '0;
            do_select = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      FETCH: begin
        rd_en_c   = 1'b1;
        rd_addr_c = {rd_bank_q, idx_q};
        state_d   = LOAD_WORD;
      end

      LOAD_WORD: begin
        sl_ch_c   = 1'b1;
        sel_mem_c = 1'b1;
        state_d   = SHIFT_WORD;
      end

      SHIFT_WORD: begin
        sel_mem_c  = 1'b1;
        shift_en_c = bus.tx_ready;
        if (bus.tx_ready) begin
          if (cnt_q == WORD_LAST) begin
            cnt_d = '0;
            if (idx_q == last_idx) begin
              // End of a bank: the ring pointer wraps naturally because
              // NBANKS is a power of two.
              idx_d     = '0;
              rd_bank_d = rd_bank_q + 1'b1;
              if (mode_q == MODE_PARTIAL) begin
                state_d      = IDLE;
                frame_done_d = 1'b1;
              end else begin
                do_select = 1'b1;
              end
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = FETCH;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      WAIT_BANK: begin
        sel_mem_c = 1'b1;
        do_select = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Full banks always drain before the partial bank is started.
    if (do_select) begin
      if (pend_cnt_q != '0) begin
        mode_d    = MODE_FULL;
        take_full = 1'b1;
        state_d   = FETCH;
      end else if (done_pend_q) begin
        mode_d       = MODE_PARTIAL;
        take_partial = 1'b1;
        state_d      = FETCH;
      end else begin
        state_d = WAIT_BANK;
      end
    end
  end

  always_comb begin : bookkeeping
    pend_cnt_d  = pend_cnt_q;
    done_pend_d = done_pend_q;
    final_d     = final_q;
    ovf_set     = 1'b0;

    // A bank arriving while the counter is already at its ceiling means the
    // writer has lapped the reader; the count saturates.
    if (bus.bank_full && pend_cnt_q == PEND_MAX) begin
      ovf_set = 1'b1;
    end

    if (bus.bank_full && !take_full) begin
      if (pend_cnt_q != PEND_MAX) begin
        pend_cnt_d = pend_cnt_q + 1'b1;
      end
    end else if (take_full && !bus.bank_full) begin
      pend_cnt_d = pend_cnt_q - 1'b1;
    end

    if (take_partial) begin
      done_pend_d = 1'b0;
    end

    // A second event end before the first partial bank started would lose
    // data; keep the original index and flag it.
    if (bus.acq_done) begin
      if (done_pend_q) begin
        ovf_set = 1'b1;
      end else begin
        done_pend_d = 1'b1;
        final_d     = bus.idx_final;
      end
    end

    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end

    sending_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= MODE_FULL;
      rd_bank_q    <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      pend_cnt_q   <= '0;
      done_pend_q  <= 1'b0;
      final_q      <= '0;
      sending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      rd_bank_q    <= rd_bank_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      pend_cnt_q   <= pend_cnt_d;
      done_pend_q  <= done_pend_d;
      final_q      <= final_d;
      sending_q    <= sending_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.rd_addr    = rd_addr_c;
  assign bus.rd_en      = rd_en_c;
  assign bus.sl_time    = sl_time_c;
  assign bus.sl_ch      = sl_ch_c;
  assign bus.shift_en   = shift_en_c;
  assign bus.sel_mem    = sel_mem_c;
  assign bus.sending    = sending_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_spectro_readout_seq.sv
module tb_spectro_readout_seq;

  localparam int NB    = 2;
  localparam int BW    = 1;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int WW    = 2;
  localparam int RW    = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  spectro_readout_if #(.BANK_W(BW), .ADDR_W(AW)) bus ();

  spectro_readout_seq #(
    .NBANKS(NB), .BANK_W(BW), .ADDR_W(AW),
    .DEPTH(DEPTH), .WORD_W(WW), .RTC_W(RW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  int   cyc;
  int   n_shift;
  int   rd_cyc[$];
  int   rd_adr[$];
  int   fd_cyc[$];
  int   slt_cyc[$];
  logic snd_log[$];
  logic sel_log[$];

  function automatic logic [BW+AW+7:0] outs();
    return {bus.rd_addr, bus.rd_en, bus.sl_time, bus.sl_ch, bus.shift_en,
            bus.sel_mem, bus.sending, bus.frame_done, bus.overflow};
  endfunction

  task automatic clear_log();
    cyc = 0;
    n_shift = 0;
    rd_cyc.delete();
    rd_adr.delete();
    fd_cyc.delete();
    slt_cyc.delete();
    snd_log.delete();
    sel_log.delete();
  endtask

  // One clock cycle: drive inputs after the falling edge, then record outputs.
  task automatic tick(input logic bf, input logic ad, input logic [AW-1:0] idf,
                      input logic rdy, input logic clr);
    @(negedge clk);
    bus.bank_full    = bf;
    bus.acq_done     = ad;
    bus.idx_final    = idf;
    bus.tx_ready     = rdy;
    bus.clr_overflow = clr;
    #1;
    if (bus.rd_en) begin
      rd_cyc.push_back(cyc);
      rd_adr.push_back(int'(bus.rd_addr));
    end
    if (bus.shift_en)   n_shift++;
    if (bus.frame_done) fd_cyc.push_back(cyc);
    if (bus.sl_time)    slt_cyc.push_back(cyc);
    snd_log.push_back(bus.sending);
    sel_log.push_back(bus.sel_mem);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset            = 1'b1;
    bus.bank_full    = 1'b0;
    bus.acq_done     = 1'b0;
    bus.idx_final    = '0;
    bus.tx_ready     = 1'b1;
    bus.clr_overflow = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    bus.bank_full    = 1'b0;
    bus.acq_done     = 1'b0;
    bus.idx_final    = '0;
    bus.tx_ready     = 1'b1;
    bus.clr_overflow = 1'b0;
    #6;
    checks++;
    if (outs() !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", outs());
    end
    checks++;
    if (dut.state_q !== 3'd0) begin
      errors++; $display("FAIL reset_state got %0d want 0", dut.state_q);
    end
    checks++;
    if ({dut.pend_cnt_q, dut.done_pend_q, dut.final_q, dut.rd_bank_q} !== '0) begin
      errors++; $display("FAIL reset_bookkeeping got %b want 0",
                         {dut.pend_cnt_q, dut.done_pend_q, dut.final_q, dut.rd_bank_q});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_short_event();
    int exp_c[3] = '{7, 11, 15};
    int exp_a[3] = '{0, 1, 2};
    int ones;
    do_reset();
    clear_log();
    tick(1'b0, 1'b1, 2'd2, 1'b1, 1'b0);
    for (int i = 1; i < 26; i++) tick(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    checks++;
    if ((slt_cyc.size() == 1 ? slt_cyc[0] : -1) !== 2) begin
      errors++; $display("FAIL short_sl_time count %0d first %0d want cycle 2",
                         slt_cyc.size(), slt_cyc.size() > 0 ? slt_cyc[0] : -1);
    end
    checks++;
    if (rd_cyc.size() !== 3) begin
      errors++; $display("FAIL short_rd_count got %0d want 3", rd_cyc.size());
    end
    for (int i = 0; i < 3 && i < rd_cyc.size(); i++) begin
      checks++;
      if (rd_cyc[i] !== exp_c[i] || rd_adr[i] !== exp_a[i]) begin
        errors++; $display("FAIL short_rd[%0d] got addr %0d cyc %0d want addr %0d cyc %0d",
                           i, rd_adr[i], rd_cyc[i], exp_a[i], exp_c[i]);
      end
    end
    checks++;
    if (n_shift !== 10) begin
      errors++; $display("FAIL short_shift_count got %0d want 10", n_shift);
    end
    checks++;
    if ((fd_cyc.size() == 1 ? fd_cyc[0] : -1) !== 19) begin
      errors++; $display("FAIL short_frame_done count %0d first %0d want one at 19",
                         fd_cyc.size(), fd_cyc.size() > 0 ? fd_cyc[0] : -1);
    end
    checks++;
    if (dut.rd_bank_q !== 1'b1) begin
      errors++; $display("FAIL short_rd_bank got %0d want 1", dut.rd_bank_q);
    end
    ones = 0;
    for (int i = 0; i < snd_log.size(); i++) if (snd_log[i] === 1'b1) ones++;
    checks++;
    if (ones !== 17 || snd_log[2] !== 1'b1 || snd_log[19] !== 1'b0) begin
      errors++; $display("FAIL short_sending high %0d cycles (c2=%b c19=%b) want 17 (1,0)",
                         ones, snd_log[2], snd_log[19]);
    end
  endtask

  task automatic test_long_event();
    int exp_c[6] = '{7, 11, 15, 19, 23, 27};
    do_reset();
    clear_log();
    for (int i = 0; i < 40; i++)
      tick(i == 0, i == 10, (i == 10) ? 2'd1 : 2'd0, 1'b1, 1'b0);
    checks++;
    if (rd_cyc.size() !== 6) begin
      errors++; $display("FAIL long_rd_count got %0d want 6", rd_cyc.size());
    end
    for (int i = 0; i < 6 && i < rd_cyc.size(); i++) begin
      checks++;
      if (rd_cyc[i] !== exp_c[i] || rd_adr[i] !== i) begin
        errors++; $display("FAIL long_rd[%0d] got addr %0d cyc %0d want addr %0d cyc %0d",
                           i, rd_adr[i], rd_cyc[i], i, exp_c[i]);
      end
    end
    checks++;
    if (n_shift !== 16) begin
      errors++; $display("FAIL long_shift_count got %0d want 16", n_shift);
    end
    checks++;
    if ((fd_cyc.size() == 1 ? fd_cyc[0] : -1) !== 31) begin
      errors++; $display("FAIL long_frame_done count %0d first %0d want one at 31",
                         fd_cyc.size(), fd_cyc.size() > 0 ? fd_cyc[0] : -1);
    end
  endtask

  task automatic test_back_pressure();
    int exp_c[3] = '{11, 17, 23};
    do_reset();
    clear_log();
    for (int i = 0; i < 36; i++)
      tick(1'b0, i == 0, (i == 0) ? 2'd2 : 2'd0, (i % 2) == 0, 1'b0);
    checks++;
    if (rd_cyc.size() !== 3) begin
      errors++; $display("FAIL bp_rd_count got %0d want 3", rd_cyc.size());
    end
    for (int i = 0; i < 3 && i < rd_cyc.size(); i++) begin
      checks++;
      if (rd_cyc[i] !== exp_c[i] || rd_adr[i] !== i) begin
        errors++; $display("FAIL bp_rd[%0d] got addr %0d cyc %0d want addr %0d cyc %0d",
                           i, rd_adr[i], rd_cyc[i], i, exp_c[i]);
      end
    end
    checks++;
    if (n_shift !== 10) begin
      errors++; $display("FAIL bp_shift_count got %0d want 10", n_shift);
    end
    // 10 stalled shift cycles push completion from 19 to 29.
    checks++;
    if ((fd_cyc.size() == 1 ? fd_cyc[0] : -1) !== 29) begin
      errors++; $display("FAIL bp_frame_done count %0d first %0d want one at 29",
                         fd_cyc.size(), fd_cyc.size() > 0 ? fd_cyc[0] : -1);
    end
  endtask

  task automatic test_wait_bank();
    int exp_c[9] = '{7, 11, 15, 19, 54, 58, 62, 66, 70};
    int exp_a[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    int snd_hi, sel_hi, rd_wait;
    do_reset();
    clear_log();
    for (int i = 0; i < 80; i++)
      tick(i == 0 || i == 52, i == 55, 2'd0, 1'b1, 1'b0);
    snd_hi = 0; sel_hi = 0; rd_wait = 0;
    for (int i = 23; i <= 53; i++) begin
      if (snd_log[i] === 1'b1) snd_hi++;
      if (sel_log[i] === 1'b1) sel_hi++;
    end
    for (int i = 0; i < rd_cyc.size(); i++)
      if (rd_cyc[i] >= 23 && rd_cyc[i] <= 53) rd_wait++;
    checks++;
    if (snd_hi !== 31 || sel_hi !== 31) begin
      errors++; $display("FAIL wait_hold sending %0d sel_mem %0d cycles want 31 each",
                         snd_hi, sel_hi);
    end
    checks++;
    if (rd_wait !== 0) begin
      errors++; $display("FAIL wait_no_read got %0d reads want 0", rd_wait);
    end
    checks++;
    if (rd_cyc.size() !== 9) begin
      errors++; $display("FAIL wait_rd_count got %0d want 9", rd_cyc.size());
    end
    for (int i = 0; i < 9 && i < rd_cyc.size(); i++) begin
      checks++;
      if (rd_cyc[i] !== exp_c[i] || rd_adr[i] !== exp_a[i]) begin
        errors++; $display("FAIL wait_rd[%0d] got addr %0d cyc %0d want addr %0d cyc %0d",
                           i, rd_adr[i], rd_cyc[i], exp_a[i], exp_c[i]);
      end
    end
    checks++;
    if ((fd_cyc.size() == 1 ? fd_cyc[0] : -1) !== 74) begin
      errors++; $display("FAIL wait_frame_done count %0d first %0d want one at 74",
                         fd_cyc.size(), fd_cyc.size() > 0 ? fd_cyc[0] : -1);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    clear_log();
    // tx_ready held low so the header never completes and no bank is taken.
    tick(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (bus.overflow !== 1'b1 || dut.pend_cnt_q !== 1'b1) begin
      errors++; $display("FAIL ovf_second_bank overflow %b pend %0d want 1 1",
                         bus.overflow, dut.pend_cnt_q);
    end
    tick(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (bus.overflow !== 1'b1 || dut.pend_cnt_q !== 1'b1) begin
      errors++; $display("FAIL ovf_third_bank overflow %b pend %0d want 1 1",
                         bus.overflow, dut.pend_cnt_q);
    end
    tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got %b want 0", bus.overflow);
    end
    tick(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set_beats_clear got %b want 1", bus.overflow);
    end
    tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (bus.overflow !== 1'b0 || dut.done_pend_q !== 1'b1 || dut.final_q !== 2'd3) begin
      errors++; $display("FAIL ovf_first_acq overflow %b done_pend %b final %0d want 0 1 3",
                         bus.overflow, dut.done_pend_q, dut.final_q);
    end
    tick(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    checks++;
    if (bus.overflow !== 1'b1 || dut.final_q !== 2'd3) begin
      errors++; $display("FAIL ovf_second_acq overflow %b final %0d want 1 3",
                         bus.overflow, dut.final_q);
    end
    checks++;
    if (n_shift !== 0 || slt_cyc.size() !== 1) begin
      errors++; $display("FAIL ovf_stalled shifts %0d loads %0d want 0 1",
                         n_shift, slt_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    clear_log();
    tick(1'b0, 1'b1, 2'd2, 1'b1, 1'b0);
    for (int i = 1; i < 10; i++) tick(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    // Cycle 9 is the first SHIFT_WORD cycle of word 0; reset between edges.
    checks++;
    if (bus.shift_en !== 1'b1 || bus.sel_mem !== 1'b1) begin
      errors++; $display("FAIL mid_pre_state shift_en %b sel_mem %b want 1 1",
                         bus.shift_en, bus.sel_mem);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (outs() !== '0) begin
      errors++; $display("FAIL mid_reset_outputs got %h want 0", outs());
    end
    checks++;
    if (dut.state_q !== 3'd0 || dut.done_pend_q !== 1'b0 || dut.pend_cnt_q !== 1'b0) begin
      errors++; $display("FAIL mid_reset_state state %0d done_pend %b pend %0d want 0 0 0",
                         dut.state_q, dut.done_pend_q, dut.pend_cnt_q);
    end
    tick(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    checks++;
    if (fd_cyc.size() !== 0 || slt_cyc.size() !== 1) begin
      errors++; $display("FAIL mid_no_resume frame_done %0d sl_time %0d want 0 1",
                         fd_cyc.size(), slt_cyc.size());
    end
  endtask

  initial begin
    test_reset();
    test_short_event();
    test_long_event();
    test_back_pressure();
    test_wait_bank();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
